// File: rtl/spi_proto_pkg.sv
// Shared definitions for the two-byte SPI register-access protocol:
// command byte layout, data widths and the master sequencer states.
package spi_proto_pkg;

    localparam int CMD_WR_BIT = 7;
    localparam int CMD_HI_BIT = 6;
    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_BYTE0    = 3'd2,
        ST_GAP      = 3'd3,
        ST_BYTE1    = 3'd4,
        ST_CS_HOLD  = 3'd5,
        ST_CS_IDLE  = 3'd6
    } state_e;

    function automatic logic [DATA_W-1:0] build_cmd(input logic wr, input logic hi,
                                                    input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] cmd;
        cmd             = '0;
        cmd[CMD_WR_BIT] = wr;
        cmd[CMD_HI_BIT] = hi;
        cmd[ADDR_W-1:0] = addr;
        return cmd;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 byte engine: shifts one byte MSB first on mosi while capturing miso,
// generating sclk from clk with a CLK_DIV half-period divider.
module spi_byte_shifter
    import spi_proto_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_byte,
    input  logic              miso,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    output logic [DATA_W-1:0] rx_byte
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic              active_q, active_d;
    logic              sclk_q, sclk_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;

    // miso is taken on the clk edge that raises sclk; mosi advances on the edge that drops it.
    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        div_d    = div_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        done     = 1'b0;
        if (start) begin
            active_d = 1'b1;
            sclk_d   = 1'b0;
            div_d    = '0;
            bit_d    = '0;
            tx_d     = tx_byte;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[DATA_W-2:0], miso};
                end else begin
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        active_d = 1'b0;
                        done     = 1'b1;
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = tx_q[DATA_W-1];
    assign rx_byte = rx_q;

endmodule

// File: rtl/spi_cmd_master.sv
// Host-side SPI initiator: turns a register read/write request into a
// command byte plus data byte frame and returns the byte read back.
module spi_cmd_master
    import spi_proto_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned BYTE_GAP = 4,
    parameter int unsigned CS_GAP   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_hi,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned MAX_A   = (CLK_DIV > BYTE_GAP) ? CLK_DIV : BYTE_GAP;
    localparam int unsigned CNT_MAX = (MAX_A > CS_GAP) ? MAX_A : CS_GAP;
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);
    localparam logic [CNT_W-1:0] CSGAP_LAST = CNT_W'(CS_GAP - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cmd_q, cmd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              sh_start, sh_done, sh_sclk, sh_mosi;
    logic [DATA_W-1:0] sh_byte, sh_rx;

    // Timed states count cnt_q up from zero and leave on their last cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        sh_start    = 1'b0;
        sh_byte     = (state_q == ST_GAP) ? data_q : cmd_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cmd_d   = build_cmd(req_write, req_hi, req_addr);
                    data_d  = req_write ? req_wdata : '0;
                    cnt_d   = '0;
                    state_d = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    sh_start = 1'b1;
                    state_d  = ST_BYTE0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BYTE0: begin
                if (sh_done) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    sh_start = 1'b1;
                    state_d  = ST_BYTE1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BYTE1: begin
                if (sh_done) begin
                    cnt_d   = '0;
                    state_d = ST_CS_HOLD;
                end
            end
            ST_CS_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_CS_IDLE;
                    if (!cmd_q[CMD_WR_BIT]) rdata_d = sh_rx;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CS_IDLE: begin
                if (cnt_q == CSGAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (sh_start),
        .tx_byte (sh_byte),
        .miso    (miso),
        .done    (sh_done),
        .sclk    (sh_sclk),
        .mosi    (sh_mosi),
        .rx_byte (sh_rx)
    );

    // Outside the shifted bytes mosi pre-presents the MSB of the byte about to go out.
    always_comb begin
        case (state_q)
            ST_CS_SETUP:        mosi = cmd_q[DATA_W-1];
            ST_BYTE0, ST_BYTE1: mosi = sh_mosi;
            ST_GAP:             mosi = data_q[DATA_W-1];
            default:            mosi = 1'b0;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = ~req_ready;
    assign cs_n      = (state_q == ST_IDLE) || (state_q == ST_CS_IDLE);
    assign sclk      = sh_sclk;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Randomised bench for spi_cmd_master: a behavioural slave with a register
// array sits on the SPI pins and each request is checked against a request-level model.
module tb_spi_cmd_master;

    localparam int CLK_DIV  = 2;
    localparam int BYTE_GAP = 4;
    localparam int CS_GAP   = 2;
    localparam int LAT      = 1 + CLK_DIV + 32 * CLK_DIV + BYTE_GAP + CLK_DIV;
    localparam int F_DIV    = 1;
    localparam int F_GAP    = 2;
    localparam int F_LAT    = 1 + F_DIV + 32 * F_DIV + F_GAP + F_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid, req_ready, req_write, req_hi;
    logic [5:0] req_addr;
    logic [7:0] req_wdata, rsp_rdata;
    logic       rsp_valid, busy, sclk, cs_n, mosi, miso;

    logic       req_valid_f, req_ready_f, rsp_valid_f, busy_f, sclk_f, cs_n_f, mosi_f;
    logic [7:0] rsp_rdata_f;
    logic       miso_f = 1'b0;

    spi_cmd_master #(.CLK_DIV(CLK_DIV), .BYTE_GAP(BYTE_GAP), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_hi(req_hi), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .sclk(sclk),
        .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_cmd_master #(.CLK_DIV(F_DIV), .BYTE_GAP(F_GAP), .CS_GAP(CS_GAP)) dut_fast (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_f), .req_ready(req_ready_f),
        .req_write(1'b1), .req_hi(1'b0), .req_addr(6'h05), .req_wdata(8'hA5),
        .rsp_valid(rsp_valid_f), .rsp_rdata(rsp_rdata_f), .busy(busy_f), .sclk(sclk_f),
        .cs_n(cs_n_f), .mosi(mosi_f), .miso(miso_f)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  slave_regs [0:127];
    logic [7:0]  exp_regs   [0:127];
    logic [7:0]  last_rdata = 8'h00;
    int          exp_frames = 0;

    logic [15:0] sh_word = '0, last_word = '0;
    int          bit_cnt = 0, frame_cnt = 0, rsp_cnt = 0;
    logic [7:0]  rd_byte = '0;
    logic        prev_cs_n = 1'b1, prev_sclk = 1'b0;

    logic [15:0] sh_word_f = '0, last_word_f = '0;
    int          bit_cnt_f = 0;
    logic        prev_cs_n_f = 1'b1, prev_sclk_f = 1'b0;

    // Slave model: captures mosi on sclk rise, serves the addressed register on
    // miso during byte 1 and commits writes only for complete 16-bit frames.
    always @(negedge clk) begin
        if (prev_cs_n && !cs_n) begin
            bit_cnt = 0;
            sh_word = '0;
            miso    = 1'($urandom);
        end else if (!prev_cs_n && cs_n) begin
            if (bit_cnt == 16) begin
                last_word = sh_word;
                frame_cnt++;
                if (sh_word[15]) slave_regs[{1'b0, sh_word[13:8]} + 7'(sh_word[14])] = sh_word[7:0];
            end
            bit_cnt = 0;
        end
        if (!cs_n && !prev_sclk && sclk) begin
            sh_word = {sh_word[14:0], mosi};
            bit_cnt++;
        end
        if (!cs_n && prev_sclk && !sclk) begin
            if (bit_cnt == 8) begin
                rd_byte = slave_regs[{1'b0, sh_word[5:0]} + 7'(sh_word[6])];
                miso    = rd_byte[7];
            end else if (bit_cnt > 8 && bit_cnt < 16) begin
                miso = rd_byte[15 - bit_cnt];
            end else if (bit_cnt < 8) begin
                miso = 1'($urandom);
            end else begin
                miso = 1'b0;
            end
        end
        if (rsp_valid) rsp_cnt++;
        prev_cs_n = cs_n;
        prev_sclk = sclk;
    end

    always @(negedge clk) begin
        if (prev_cs_n_f && !cs_n_f) begin
            bit_cnt_f = 0;
            sh_word_f = '0;
        end else if (!prev_cs_n_f && cs_n_f && bit_cnt_f == 16) begin
            last_word_f = sh_word_f;
        end
        if (!cs_n_f && !prev_sclk_f && sclk_f) begin
            sh_word_f = {sh_word_f[14:0], mosi_f};
            bit_cnt_f++;
        end
        prev_cs_n_f = cs_n_f;
        prev_sclk_f = sclk_f;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic hi, input logic [5:0] addr,
                                 input logic [7:0] wd);
        int          t_acc;
        int          n;
        logic [6:0]  idx;
        logic [7:0]  exp_rd;
        logic [15:0] exp_word;
        idx      = {1'b0, addr} + 7'(hi);
        exp_word = {wr, hi, addr, (wr ? wd : 8'h00)};
        exp_rd   = wr ? last_rdata : exp_regs[idx];
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checkOutput("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_hi    = hi;
        req_addr  = addr;
        req_wdata = wd;
        t_acc     = cyc;
        @(negedge clk);
        checkOutput("busy_after_accept", {30'd0, busy, req_ready}, 32'h2);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_hi    = 1'($urandom);
        req_addr  = 6'($urandom);
        req_wdata = 8'($urandom);
        n = 0;
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rsp_latency", cyc - t_acc, LAT);
        checkOutput("cs_n_at_rsp", 32'(cs_n), 32'd1);
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        @(negedge clk);
        checkOutput("rsp_pulse_width", 32'(rsp_valid), 32'd0);
        checkOutput("mosi_frame", 32'(last_word), 32'(exp_word));
        exp_frames++;
        checkOutput("frame_count", frame_cnt, exp_frames);
        if (wr) exp_regs[idx] = wd;
        else    last_rdata    = exp_rd;
    endtask

    initial begin
        int n;
        int t0, t_rise, t2, rsp_before;
        for (int i = 0; i < 128; i++) begin
            slave_regs[i] = 8'($urandom);
            exp_regs[i]   = slave_regs[i];
        end
        req_valid = 1'b0; req_write = 1'b0; req_hi = 1'b0;
        req_addr = '0; req_wdata = '0; req_valid_f = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        checkOutput("reset_sclk", 32'(sclk), 32'd0);
        checkOutput("reset_cs_n", 32'(cs_n), 32'd1);
        checkOutput("reset_mosi", 32'(mosi), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fast divider instance: sclk = clk/2 with the minimum byte gap.
        req_valid_f = 1'b1;
        t0 = cyc;
        @(negedge clk);
        req_valid_f = 1'b0;
        n = 0;
        while (!rsp_valid_f && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fast_latency", cyc - t0, F_LAT);
        @(negedge clk);
        checkOutput("fast_frame", 32'(last_word_f), 32'h85A5);

        applyStimulus(1'b1, 1'b0, 6'h05, 8'hA5);
        applyStimulus(1'b1, 1'b1, 6'h10, 8'h3C);
        checkOutput("slave_reg_0x11", 32'(slave_regs[7'h11]), 32'h3C);
        slave_regs[7'h0B] = 8'h5E;
        exp_regs[7'h0B]   = 8'h5E;
        applyStimulus(1'b0, 1'b1, 6'h0A, 8'hFF);

        // Back-to-back writes with req_valid held, then a pulse while busy.
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_write = 1'b1; req_hi = 1'b0; req_addr = 6'h2A; req_wdata = 8'h11;
        @(negedge clk);
        req_hi = 1'b1; req_addr = 6'h2B; req_wdata = 8'h22;
        t_rise = -1000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (rsp_valid) t_rise = cyc;
        end while (!req_ready && n < 300);
        t2 = cyc;
        checkOutput("b2b_accept_gap", t2 - t_rise, CS_GAP);
        checkOutput("b2b_frame1", 32'(last_word), 32'hAA11);
        exp_regs[7'h2A] = 8'h11;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (20) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h01;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_latency2", cyc - t2, LAT);
        @(negedge clk);
        checkOutput("b2b_frame2", 32'(last_word), 32'hEB22);
        exp_regs[7'h2C] = 8'h22;
        exp_frames += 2;
        repeat (100) @(negedge clk);
        checkOutput("no_extra_frame", frame_cnt, exp_frames);
        checkOutput("b2b_rdata_held", 32'(rsp_rdata), 32'(last_rdata));

        // Asynchronous reset during bit 3 of the command byte.
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_write = 1'b1; req_hi = 1'b0; req_addr = 6'h21; req_wdata = 8'h77;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (bit_cnt < 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_cs_n", 32'(cs_n), 32'd1);
        checkOutput("midrst_sclk", 32'(sclk), 32'd0);
        checkOutput("midrst_mosi", 32'(mosi), 32'd0);
        checkOutput("midrst_ready", {30'd0, busy, req_ready}, 32'h1);
        checkOutput("midrst_rdata", 32'(rsp_rdata), 32'd0);
        rsp_before = rsp_cnt;
        last_rdata = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("midrst_no_rsp", rsp_cnt, rsp_before);
        checkOutput("midrst_no_frame", frame_cnt, exp_frames);
        applyStimulus(1'b0, 1'b0, 6'h21, 8'h00);

        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
